// File: rtl/data_mem_responder.sv
// data_mem_responder
// Services load/store strobes from the controller against an internal
// word-addressed RAM of 2^DEPTH_LOG2 32-bit words. Each access stalls the
// pipeline for WAIT_STATES+1 cycles and completes in a single DONE cycle.
// Load data is registered and is presented in the DONE cycle.
//
// Optional feature macro: MEM_ALIGN_CHECK_EN
//   defined   : accesses with addr[1:0] != 0 are rejected. A read+write
//               collision is flagged as well. Both are reported on
//               misalign_err.
//   undefined : addr[1:0] is ignored and misalign_err is tied low.
module data_mem_responder #(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  memctrl,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        stall,
    output logic        misalign_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam bit HAS_WAIT = (WAIT_STATES > 0);
    localparam logic [3:0] CNT_LOAD = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // A byte address is misaligned when it does not point at a word boundary.
    function automatic logic is_misaligned(input logic [31:0] a);
        return (a[1:0] != 2'b00);
    endfunction

    state_t                  state_r;
    state_t                  state_next_s;
    logic [3:0]              cnt_r;
    logic [3:0]              cnt_next_s;

    logic                    req_s;
    logic                    bad_live_s;
    logic                    commit_s;

    // Operation latched in IDLE so later input changes cannot disturb it
    logic                    op_rd_r;
    logic                    op_wr_r;
    logic                    op_coll_r;
    logic                    op_bad_r;
    logic [DEPTH_LOG2-1:0]   op_idx_r;
    logic [31:0]             op_wdata_r;

    // Operation used by the commit: live inputs in IDLE (needed when there
    // are no wait states), otherwise the latched copy
    logic                    cur_rd_s;
    logic                    cur_wr_s;
    logic                    cur_coll_s;
    logic                    cur_bad_s;
    logic [DEPTH_LOG2-1:0]   cur_idx_s;
    logic [31:0]             cur_wdata_s;

    logic [31:0]             mem_r [0:DEPTH-1];
    logic                    unused_s;

    assign req_s = memctrl[2] | memctrl[1];

`ifdef MEM_ALIGN_CHECK_EN
    assign bad_live_s = is_misaligned(addr);
    assign unused_s   = ^{memctrl[0], addr[31:DEPTH_LOG2+2]};
`else
    assign bad_live_s = 1'b0;
    assign unused_s   = ^{memctrl[0], addr[31:DEPTH_LOG2+2], addr[1:0], cur_coll_s};
`endif

    // Stall holds the pipeline while a request is pending; forced low in reset
    assign stall = reset & (((state_r == IDLE) & req_s) | (state_r == WAIT));

    // State and wait counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Next-state and wait-counter logic
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (req_s) begin
                    cnt_next_s   = CNT_LOAD;
                    state_next_s = HAS_WAIT ? WAIT : DONE;
                end else begin
                    cnt_next_s   = 4'd0;
                    state_next_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == 4'd0) begin
                    cnt_next_s   = 4'd0;
                    state_next_s = DONE;
                end else begin
                    cnt_next_s   = cnt_r - 4'd1;
                    state_next_s = WAIT;
                end
            end
            DONE: begin
                cnt_next_s   = 4'd0;
                state_next_s = IDLE;
            end
            default: begin
                cnt_next_s   = 4'd0;
                state_next_s = IDLE;
            end
        endcase
    end

    // DONE is only ever entered from IDLE or WAIT, so this marks the commit edge
    assign commit_s = reset & (state_next_s == DONE);

    // Capture the request in IDLE; read wins over write on a collision
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_rd_r    <= 1'b0;
            op_wr_r    <= 1'b0;
            op_coll_r  <= 1'b0;
            op_bad_r   <= 1'b0;
            op_idx_r   <= '0;
            op_wdata_r <= 32'd0;
        end else if ((state_r == IDLE) && req_s) begin
            op_rd_r    <= memctrl[2];
            op_wr_r    <= memctrl[1] & ~memctrl[2];
            op_coll_r  <= memctrl[2] & memctrl[1];
            op_bad_r   <= bad_live_s;
            op_idx_r   <= addr[DEPTH_LOG2+1:2];
            op_wdata_r <= wdata;
        end
    end

    // Select live or latched operation for the commit
    always_comb begin
        cur_rd_s    = 1'b0;
        cur_wr_s    = 1'b0;
        cur_coll_s  = 1'b0;
        cur_bad_s   = 1'b0;
        cur_idx_s   = '0;
        cur_wdata_s = 32'd0;
        if (state_r == IDLE) begin
            cur_rd_s    = memctrl[2];
            cur_wr_s    = memctrl[1] & ~memctrl[2];
            cur_coll_s  = memctrl[2] & memctrl[1];
            cur_bad_s   = bad_live_s;
            cur_idx_s   = addr[DEPTH_LOG2+1:2];
            cur_wdata_s = wdata;
        end else begin
            cur_rd_s    = op_rd_r;
            cur_wr_s    = op_wr_r;
            cur_coll_s  = op_coll_r;
            cur_bad_s   = op_bad_r;
            cur_idx_s   = op_idx_r;
            cur_wdata_s = op_wdata_r;
        end
    end

    // RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (commit_s && cur_wr_s && !cur_bad_s) begin
            mem_r[cur_idx_s] <= cur_wdata_s;
        end
    end

    // Load data and valid pulse, updated on the commit edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata       <= 32'd0;
            rdata_valid <= 1'b0;
        end else begin
            rdata_valid <= commit_s & cur_rd_s & ~cur_bad_s;
            if (commit_s && cur_rd_s) begin
                rdata <= cur_bad_s ? 32'd0 : mem_r[cur_idx_s];
            end
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    // Error pulse for rejected or colliding accesses, aligned with DONE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= commit_s & (cur_bad_s | cur_coll_s);
        end
    end
`else
    assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one instance with WAIT_STATES=2 and one with
// WAIT_STATES=0. A reference memory per instance predicts load data, which is
// queued when a read is issued and popped when the DONE cycle is reached.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  mc_a, mc_b;
    logic [31:0] addr_a, addr_b, wd_a, wd_b;
    logic [31:0] rdata_a, rdata_b;
    logic        valid_a, valid_b, stall_a, stall_b, err_a, err_b;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] model_a [0:255];
    logic [31:0] model_b [0:255];
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_LOG2(8), .WAIT_STATES(2)) dut_a (
        .clk(clk), .reset(reset), .memctrl(mc_a), .addr(addr_a), .wdata(wd_a),
        .rdata(rdata_a), .rdata_valid(valid_a), .stall(stall_a), .misalign_err(err_a)
    );

    data_mem_responder #(.DEPTH_LOG2(8), .WAIT_STATES(0)) dut_b (
        .clk(clk), .reset(reset), .memctrl(mc_b), .addr(addr_b), .wdata(wd_b),
        .rdata(rdata_b), .rdata_valid(valid_b), .stall(stall_b), .misalign_err(err_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic [2:0] mc, input logic [31:0] a, input logic [31:0] wd);
        if (sel) begin
            mc_b = mc; addr_b = a; wd_b = wd;
        end else begin
            mc_a = mc; addr_a = a; wd_a = wd;
        end
    endtask

    function automatic logic get_stall(input bit sel);
        return sel ? stall_b : stall_a;
    endfunction

    // One complete access: issue in IDLE, scramble inputs during the access,
    // then check stall length and DONE-cycle outputs.
    task automatic access(input string tag, input bit sel, input logic [2:0] mc,
                          input logic [31:0] a, input logic [31:0] wd);
        int   ws;
        int   sc;
        bit   rd, wr, coll, mis;
        logic [7:0] idx;
        ws   = sel ? 0 : 2;
        sc   = 0;
        rd   = mc[2];
        wr   = mc[1] & ~mc[2];
        coll = mc[2] & mc[1];
        idx  = a[9:2];
`ifdef MEM_ALIGN_CHECK_EN
        mis = (a[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        if (rd && !mis) exp_q.push_back(sel ? model_b[idx] : model_a[idx]);
        @(negedge clk);
        drive(sel, mc, a, wd);
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!get_stall(sel)) break;
            sc++;
            @(posedge clk);
            #1;
            drive(sel, 3'b000, $urandom, $urandom);
            @(negedge clk);
        end
        if (!(rd || wr)) begin
            chk({tag, "/nostall"}, 32'(sc), 32'd0);
            drive(sel, 3'b000, 32'd0, 32'd0);
            return;
        end
        chk({tag, "/stall_cycles"}, 32'(sc), 32'(ws + 1));
        chk({tag, "/valid"}, {31'd0, sel ? valid_b : valid_a}, {31'd0, rd & ~mis});
        if (rd && !mis) begin
            if (exp_q.size() == 0) begin
                chk({tag, "/queue"}, 32'd0, 32'd1);
            end else begin
                chk({tag, "/rdata"}, sel ? rdata_b : rdata_a, exp_q.pop_front());
            end
        end else if (rd) begin
            chk({tag, "/rdata_rejected"}, sel ? rdata_b : rdata_a, 32'd0);
        end
`ifdef MEM_ALIGN_CHECK_EN
        chk({tag, "/err"}, {31'd0, sel ? err_b : err_a}, {31'd0, mis | coll});
`else
        chk({tag, "/err"}, {31'd0, sel ? err_b : err_a}, {31'd0, 1'b0 & coll});
`endif
        if (wr && !mis) begin
            if (sel) model_b[idx] = wd;
            else     model_a[idx] = wd;
        end
    endtask

    // Global time limit
    initial begin
        #200000;
        $display("FAIL timeout: observed no completion expected summary");
        $fatal(1, "bench timed out");
    end

    initial begin
        logic [31:0] ra [0:5];
        reset = 1'b0;
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        drive(1'b1, 3'b000, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        drive(1'b0, 3'b100, 32'h10, 32'd0);
        #1;
        chk("reset/stall_with_req", {31'd0, stall_a}, 32'd0);
        drive(1'b0, 3'b000, 32'd0, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("reset/rdata", rdata_a, 32'd0);
        chk("reset/valid", {31'd0, valid_a}, 32'd0);
        chk("reset/err", {31'd0, err_a}, 32'd0);
        chk("reset/stall", {31'd0, stall_a}, 32'd0);

        access("regwrite_only", 1'b0, 3'b001, 32'h40, 32'h1234);

        access("store_10", 1'b0, 3'b010, 32'h10, 32'hDEADBEEF);
        access("load_10",  1'b0, 3'b100, 32'h10, 32'h0);

        access("wrap_store", 1'b0, 3'b010, 32'h400, 32'hA5A5A5A5);
        access("wrap_load",  1'b0, 3'b100, 32'h000, 32'h0);

        access("coll_prep",  1'b0, 3'b010, 32'h20, 32'h7);
        access("coll",       1'b0, 3'b110, 32'h20, 32'h9);
        access("coll_after", 1'b0, 3'b100, 32'h20, 32'h0);

        access("mis_store",  1'b0, 3'b010, 32'h22, 32'h55);
        access("mis_word8",  1'b0, 3'b100, 32'h20, 32'h0);
        access("mis_load",   1'b0, 3'b100, 32'h23, 32'h0);

        // Back-to-back with no wait states
        access("ws0_store", 1'b1, 3'b010, 32'h0, 32'h1);
        access("ws0_load",  1'b1, 3'b100, 32'h0, 32'h0);
        access("ws0_store2", 1'b1, 3'b010, 32'h7C, 32'hCAFEF00D);
        access("ws0_load2",  1'b1, 3'b100, 32'h47C, 32'h0);

        // Random aligned stores followed by loads
        for (int i = 0; i < 6; i++) begin
            ra[i] = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            access("rnd_store", 1'b0, 3'b010, ra[i], $urandom);
        end
        for (int i = 0; i < 6; i++) begin
            access("rnd_load", 1'b0, 3'b100, ra[i], 32'h0);
        end

        // Reset in the middle of a write is abandoned
        access("w5_old", 1'b0, 3'b010, 32'h14, 32'h11112222);
        access("r10_again", 1'b0, 3'b100, 32'h10, 32'h0);
        @(negedge clk);
        drive(1'b0, 3'b010, 32'h14, 32'h33334444);
        @(posedge clk);
        #1;
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        #2;
        reset = 1'b0;
        #1;
        chk("midreset/rdata", rdata_a, 32'd0);
        chk("midreset/valid", {31'd0, valid_a}, 32'd0);
        chk("midreset/err", {31'd0, err_a}, 32'd0);
        chk("midreset/stall", {31'd0, stall_a}, 32'd0);
        drive(1'b0, 3'b100, 32'h14, 32'h0);
        @(negedge clk);
        #1;
        chk("midreset/stall_req", {31'd0, stall_a}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        reset = 1'b1;
        access("w5_after_reset", 1'b0, 3'b100, 32'h14, 32'h0);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
